// File: rtl/dlx_ext_pkg.sv
// Shared definitions for the extended-DLX result path: data width and the
// output-port select encodings used by the result demux.
package dlx_ext_pkg;

    localparam int DATA_W = 16;

    typedef enum logic {
        OUT0 = 1'b0,
        OUT1 = 1'b1
    } out_sel_e;

endpackage

// File: rtl/sync_fifo_16bit.sv
// Single-clock FIFO with occupancy count and synchronous flush. The head word
// is presented combinationally and reads as zero while the FIFO is empty.
module sync_fifo_16bit
    import dlx_ext_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Push into a full FIFO is refused even when the head pops this cycle.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/demux_16bit_buf.sv
// Routes one valid/ready stream to one of two buffered consumer ports chosen
// per word by in_sel; each port has its own FIFO so one stall does not block the other.
module demux_16bit_buf
    import dlx_ext_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out0_data,
    output logic                    out0_valid,
    input  logic                    out0_ready,
    output logic [WIDTH-1:0]        out1_data,
    output logic                    out1_valid,
    input  logic                    out1_ready,
    output logic [$clog2(DEPTH):0]  count0,
    output logic [$clog2(DEPTH):0]  count1
);

    logic w_full0, w_full1;
    logic w_empty0, w_empty1;
    logic w_to_out1;
    logic w_sel_full;
    logic w_push;

    // Ready depends only on the selected FIFO's fill level, never on out*_ready.
    assign w_to_out1  = (out_sel_e'(in_sel) == OUT1);
    assign w_sel_full = w_to_out1 ? w_full1 : w_full0;
    assign in_ready   = ~w_sel_full & ~flush;
    assign w_push     = in_valid & in_ready;
    assign out0_valid = ~w_empty0;
    assign out1_valid = ~w_empty1;

    sync_fifo_16bit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_push  (w_push & ~w_to_out1),
        .i_wdata (in_data),
        .i_pop   (out0_ready),
        .o_rdata (out0_data),
        .o_full  (w_full0),
        .o_empty (w_empty0),
        .o_count (count0)
    );

    sync_fifo_16bit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_push  (w_push & w_to_out1),
        .i_wdata (in_data),
        .i_pop   (out1_ready),
        .o_rdata (out1_data),
        .o_full  (w_full1),
        .o_empty (w_empty1),
        .o_count (count1)
    );

    // Producer must hold the offered word until it is taken (it may withdraw valid).
    a_hold_word: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready) |=> (!in_valid || ($stable(in_data) && $stable(in_sel))));

endmodule

// File: tb/tb_demux_16bit_buf.sv
// Testbench for demux_16bit_buf: directed scenarios plus randomized traffic,
// checked by a queue-based reference model sampled on the falling clock edge.
module tb_demux_16bit_buf;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [15:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [1:0]  count0;
    logic [1:0]  count1;

    int checks   = 0;
    int failures = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic        e_rdy;
    logic        acc;

    demux_16bit_buf #(.WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .count0     (count0),
        .count1     (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: two word queues; each output shows its queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            e_rdy = ((in_sel ? q1.size() : q0.size()) < DEPTH) && !flush;
            check("sb_in_ready", 32'(in_ready), 32'(e_rdy));
            check("sb_count0", 32'(count0), 32'(q0.size()));
            check("sb_count1", 32'(count1), 32'(q1.size()));
            check("sb_out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
            check("sb_out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
            if (q0.size() != 0) check("sb_out0_data", 32'(out0_data), 32'(q0[0]));
            if (q1.size() != 0) check("sb_out1_data", 32'(out1_data), 32'(q1[0]));
            if (flush) begin
                q0.delete();
                q1.delete();
            end else begin
                if (q0.size() != 0 && out0_ready) void'(q0.pop_front());
                if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
                if (in_valid && e_rdy) begin
                    if (in_sel) q1.push_back(in_data);
                    else        q0.push_back(in_data);
                end
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge, return at the falling edge.
    task automatic cyc(input logic v, input logic s, input logic [15:0] d,
                       input logic r0, input logic r1, input logic f);
        @(posedge clk);
        #1;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        flush      = f;
        @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out0_valid"}, 32'(out0_valid), 32'd0);
        check({tag, "_out1_valid"}, 32'(out1_valid), 32'd0);
        check({tag, "_count0"}, 32'(count0), 32'd0);
        check({tag, "_count1"}, 32'(count1), 32'd0);
        check({tag, "_out0_data"}, 32'(out0_data), 32'd0);
        check({tag, "_out1_data"}, 32'(out1_data), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 16'hFFFF;
        out0_ready = 1'b1;
        out1_ready = 1'b1;

        // Reset held with a word offered
        #1;
        check_cleared("rst");
        repeat (3) @(negedge clk);
        check_cleared("rst_hold");
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Routing and one-cycle latency
        cyc(1'b1, 1'b0, 16'hA5A5, 1'b1, 1'b1, 1'b0);
        check("route_acc0", 32'(in_ready), 32'd1);
        cyc(1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b1, 1'b0);
        check("route_out0_valid", 32'(out0_valid), 32'd1);
        check("route_out0_data", 32'(out0_data), 32'hA5A5);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("route_out1_valid", 32'(out1_valid), 32'd1);
        check("route_out1_data", 32'(out1_data), 32'h5A5A);
        check("route_out0_popped", 32'(out0_valid), 32'd0);

        // Backpressure on out0; out1 still accepts
        cyc(1'b1, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_count0", 32'(count0), 32'd2);
        cyc(1'b1, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b0);
        check("bp_still_stalled", 32'(in_ready), 32'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 16'h00BB, 1'b0, 1'b1, 1'b0);
        check("bp_sel1_accept", 32'(in_ready), 32'd1);
        cyc(1'b1, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0);
        check("bp_no_passthru", 32'(in_ready), 32'd0);
        check("bp_head_0001", 32'(out0_data), 32'h0001);
        cyc(1'b1, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0);
        check("bp_accept3", 32'(in_ready), 32'd1);
        check("bp_head_0002", 32'(out0_data), 32'h0002);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("bp_head_0003", 32'(out0_data), 32'h0003);
        repeat (3) cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

        // Full FIFO with a pop: refused, then accepted; count 2 -> 1 -> 2
        cyc(1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0102, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0103, 1'b1, 1'b0, 1'b0);
        check("fp_refused", 32'(in_ready), 32'd0);
        check("fp_count_2", 32'(count0), 32'd2);
        cyc(1'b1, 1'b0, 16'h0103, 1'b0, 1'b0, 1'b0);
        check("fp_accepted", 32'(in_ready), 32'd1);
        check("fp_count_1", 32'(count0), 32'd1);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("fp_count_2b", 32'(count0), 32'd2);

        // Flush with both FIFOs occupied; pops during flush are discarded
        cyc(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        check("fl_in_ready", 32'(in_ready), 32'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_cleared("fl");

        // Asynchronous reset between edges
        cyc(1'b1, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("ar_pre_count0", 32'(count0), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_cleared("ar");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("ar_in_ready", 32'(in_ready), 32'd1);

        // Randomized traffic; an unaccepted word is held until taken
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!(in_valid && !acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 1'($urandom_range(0, 1));
                in_data  = 16'($urandom);
            end
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 63) == 0);
        end
        repeat (6) cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("end_count0", 32'(count0), 32'd0);
        check("end_count1", 32'(count1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
